// File: rtl/clasificador_fifos_vc.sv
// rtl/clasificador_fifos_vc.sv - VC classifier feeding two virtual-channel FIFOs
// Splits incoming words by bit DATA_W-1 into VC0/VC1 FIFOs with registered heads for the arbiter.

module vc_fifo #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 4,
  parameter int AF     = 3
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_push,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_empty,
  output logic              o_almost_full,
  output logic              o_drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_rdata;
  logic              w_full;
  logic              w_do_pop;
  logic              w_do_push;

  assign w_full        = (r_count == CW'(DEPTH));
  assign o_empty       = (r_count == '0);
  assign o_almost_full = (r_count >= CW'(AF));
  assign o_rdata       = r_rdata;

  // A pop on an empty FIFO is ignored, so a same-cycle push never bypasses to the head.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);
  assign o_drop    = i_push && w_full && !w_do_pop;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_rdata  <= r_mem[r_rd_ptr];
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module clasificador_fifos_vc #(
  parameter int DATA_W    = 6,
  parameter int VC0_DEPTH = 16,
  parameter int VC1_DEPTH = 4,
  parameter int VC0_AF    = 12,
  parameter int VC1_AF    = 3
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] data_in,
  input  logic              push_in,
  input  logic              VC0_pop,
  input  logic              VC1_pop,
  output logic [DATA_W-1:0] VC0,
  output logic [DATA_W-1:0] VC1,
  output logic              VC0_empty,
  output logic              VC1_empty,
  output logic              VC0_almost_full,
  output logic              VC1_almost_full,
  output logic              pause_out,
  output logic              overflow_err
);
  logic w_push_vc0;
  logic w_push_vc1;
  logic w_drop_vc0;
  logic w_drop_vc1;
  logic r_overflow;

  assign w_push_vc0 = push_in && !data_in[DATA_W-1];
  assign w_push_vc1 = push_in &&  data_in[DATA_W-1];

  vc_fifo #(.DATA_W(DATA_W), .DEPTH(VC0_DEPTH), .AF(VC0_AF)) u_vc0 (
    .clk           (clk),
    .reset_L       (reset_L),
    .i_wdata       (data_in),
    .i_push        (w_push_vc0),
    .i_pop         (VC0_pop),
    .o_rdata       (VC0),
    .o_empty       (VC0_empty),
    .o_almost_full (VC0_almost_full),
    .o_drop        (w_drop_vc0)
  );

  vc_fifo #(.DATA_W(DATA_W), .DEPTH(VC1_DEPTH), .AF(VC1_AF)) u_vc1 (
    .clk           (clk),
    .reset_L       (reset_L),
    .i_wdata       (data_in),
    .i_push        (w_push_vc1),
    .i_pop         (VC1_pop),
    .o_rdata       (VC1),
    .o_empty       (VC1_empty),
    .o_almost_full (VC1_almost_full),
    .o_drop        (w_drop_vc1)
  );

  assign pause_out    = VC0_almost_full || VC1_almost_full;
  assign overflow_err = r_overflow;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_overflow <= 1'b0;
    end else if (w_drop_vc0 || w_drop_vc1) begin
      r_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_clasificador_fifos_vc.sv
// tb/tb_clasificador_fifos_vc.sv - directed bench for clasificador_fifos_vc
module tb_clasificador_fifos_vc;
  logic       clk = 1'b0;
  logic       reset_L;
  logic [5:0] data_in;
  logic       push_in;
  logic       VC0_pop;
  logic       VC1_pop;
  logic [5:0] VC0;
  logic [5:0] VC1;
  logic       VC0_empty;
  logic       VC1_empty;
  logic       VC0_almost_full;
  logic       VC1_almost_full;
  logic       pause_out;
  logic       overflow_err;

  int tests_run = 0;
  int tests_failed = 0;

  clasificador_fifos_vc dut (
    .clk             (clk),
    .reset_L         (reset_L),
    .data_in         (data_in),
    .push_in         (push_in),
    .VC0_pop         (VC0_pop),
    .VC1_pop         (VC1_pop),
    .VC0             (VC0),
    .VC1             (VC1),
    .VC0_empty       (VC0_empty),
    .VC1_empty       (VC1_empty),
    .VC0_almost_full (VC0_almost_full),
    .VC1_almost_full (VC1_almost_full),
    .pause_out       (pause_out),
    .overflow_err    (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push_in = 1'b0;
    VC0_pop = 1'b0;
    VC1_pop = 1'b0;
    data_in = 6'h00;
  endtask

  task automatic do_reset();
    idle();
    reset_L = 1'b0;
    tick();
    reset_L = 1'b1;
    tick();
  endtask

  task automatic push_word(input logic [5:0] w);
    push_in = 1'b1;
    data_in = w;
    tick();
    idle();
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    push_in = 1'b1;
    data_in = 6'h25;
    VC0_pop = 1'b1;
    VC1_pop = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (VC0 !== 6'h00 || VC1 !== 6'h00) begin
      tests_failed++;
      $display("FAIL reset_data VC0=%h VC1=%h expected 00 00", VC0, VC1);
    end
    tests_run++;
    if (VC0_empty !== 1'b1 || VC1_empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_empty got %b%b expected 11", VC0_empty, VC1_empty);
    end
    tests_run++;
    if (pause_out !== 1'b0 || overflow_err !== 1'b0 || VC0_almost_full !== 1'b0 || VC1_almost_full !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags pause=%b ovf=%b af=%b%b expected 0 0 00", pause_out, overflow_err, VC0_almost_full, VC1_almost_full);
    end
    idle();
    reset_L = 1'b1;
    tick();
  endtask

  task automatic test_classify();
    push_word(6'h05);
    push_word(6'h21);
    tests_run++;
    if (VC0_empty !== 1'b0 || VC1_empty !== 1'b0) begin
      tests_failed++;
      $display("FAIL classify_nonempty got %b%b expected 00", VC0_empty, VC1_empty);
    end
    VC0_pop = 1'b1;
    VC1_pop = 1'b1;
    tick();
    idle();
    tests_run++;
    if (VC0 !== 6'h05 || VC1 !== 6'h21) begin
      tests_failed++;
      $display("FAIL classify_data VC0=%h VC1=%h expected 05 21", VC0, VC1);
    end
    tests_run++;
    if (VC0_empty !== 1'b1 || VC1_empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL classify_empty got %b%b expected 11", VC0_empty, VC1_empty);
    end
  endtask

  task automatic test_vc0_wrap();
    for (int i = 0; i < 16; i++) begin
      push_word(6'(i));
      if (i == 10 || i == 11) begin
        tests_run++;
        if (VC0_almost_full !== (i == 11) || pause_out !== (i == 11)) begin
          tests_failed++;
          $display("FAIL vc0_af_after_push%0d af=%b pause=%b expected %b", i + 1, VC0_almost_full, pause_out, (i == 11));
        end
      end
    end
    tests_run++;
    if (overflow_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL vc0_full_no_ovf got %b expected 0", overflow_err);
    end
    for (int i = 0; i < 16; i++) begin
      VC0_pop = 1'b1;
      tick();
      idle();
      tests_run++;
      if (VC0 !== 6'(i)) begin
        tests_failed++;
        $display("FAIL vc0_order%0d got %h expected %h", i, VC0, 6'(i));
      end
    end
    tests_run++;
    if (VC0_empty !== 1'b1 || VC0_almost_full !== 1'b0) begin
      tests_failed++;
      $display("FAIL vc0_drained empty=%b af=%b expected 1 0", VC0_empty, VC0_almost_full);
    end
    push_word(6'h0A);
    VC0_pop = 1'b1;
    tick();
    idle();
    tests_run++;
    if (VC0 !== 6'h0A) begin
      tests_failed++;
      $display("FAIL vc0_wrap got %h expected 0a", VC0);
    end
  endtask

  task automatic test_vc1_overflow();
    for (int i = 0; i < 4; i++) push_word(6'h20 + 6'(i));
    tests_run++;
    if (VC1_almost_full !== 1'b1 || overflow_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL vc1_full af=%b ovf=%b expected 1 0", VC1_almost_full, overflow_err);
    end
    push_word(6'h24);
    tests_run++;
    if (overflow_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL vc1_overflow got %b expected 1", overflow_err);
    end
    for (int i = 0; i < 4; i++) begin
      VC1_pop = 1'b1;
      tick();
      idle();
      tests_run++;
      if (VC1 !== 6'h20 + 6'(i)) begin
        tests_failed++;
        $display("FAIL vc1_pop%0d got %h expected %h", i, VC1, 6'h20 + 6'(i));
      end
    end
    VC1_pop = 1'b1;
    tick();
    idle();
    tests_run++;
    if (VC1_empty !== 1'b1 || VC1 !== 6'h23 || overflow_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL vc1_after_drain empty=%b VC1=%h ovf=%b expected 1 23 1", VC1_empty, VC1, overflow_err);
    end
  endtask

  task automatic test_full_pop();
    logic [5:0] exp_q [5];
    exp_q = '{6'h31, 6'h32, 6'h33, 6'h3F, 6'h3F};
    do_reset();
    for (int i = 0; i < 4; i++) push_word(6'h30 + 6'(i));
    push_in = 1'b1;
    data_in = 6'h3F;
    VC1_pop = 1'b1;
    tick();
    idle();
    tests_run++;
    if (VC1 !== 6'h30 || overflow_err !== 1'b0 || VC1_almost_full !== 1'b1 || VC1_empty !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_pushpop VC1=%h ovf=%b af=%b empty=%b expected 30 0 1 0", VC1, overflow_err, VC1_almost_full, VC1_empty);
    end
    for (int i = 0; i < 4; i++) begin
      VC1_pop = 1'b1;
      tick();
      idle();
      tests_run++;
      if (VC1 !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL full_drain%0d got %h expected %h", i, VC1, exp_q[i]);
      end
    end
    tests_run++;
    if (VC1_empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_drain_empty got %b expected 1", VC1_empty);
    end
  endtask

  task automatic test_empty_pushpop_reset();
    push_word(6'h07);
    VC0_pop = 1'b1;
    tick();
    idle();
    push_in = 1'b1;
    data_in = 6'h11;
    VC0_pop = 1'b1;
    tick();
    idle();
    tests_run++;
    if (VC0 !== 6'h07 || VC0_empty !== 1'b0) begin
      tests_failed++;
      $display("FAIL empty_pushpop VC0=%h empty=%b expected 07 0", VC0, VC0_empty);
    end
    push_word(6'h2A);
    push_word(6'h2B);
    push_word(6'h2C);
    VC1_pop = 1'b1;
    tick();
    idle();
    @(negedge clk);
    #2;
    reset_L = 1'b0;
    #1;
    tests_run++;
    if (VC0 !== 6'h00 || VC1 !== 6'h00 || VC0_empty !== 1'b1 || VC1_empty !== 1'b1 ||
        pause_out !== 1'b0 || overflow_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset VC0=%h VC1=%h empty=%b%b pause=%b ovf=%b expected 00 00 11 0 0",
               VC0, VC1, VC0_empty, VC1_empty, pause_out, overflow_err);
    end
    tick();
    reset_L = 1'b1;
    VC0_pop = 1'b1;
    VC1_pop = 1'b1;
    tick();
    idle();
    tests_run++;
    if (VC0 !== 6'h00 || VC1 !== 6'h00 || VC0_empty !== 1'b1 || VC1_empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_reset_pop VC0=%h VC1=%h empty=%b%b expected 00 00 11", VC0, VC1, VC0_empty, VC1_empty);
    end
  endtask

  initial begin
    idle();
    reset_L = 1'b0;
    test_reset();
    test_classify();
    test_vc0_wrap();
    test_vc1_overflow();
    test_full_pop();
    test_empty_pushpop_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
